// File: rtl/gpu_pixel_arbiter_pkg.sv
// Shared pixel geometry, source encodings and the output-stage pixel record
// for the framebuffer write-path arbiter.
package gpu_pixel_arbiter_pkg;

    localparam int WIDTH_BITS  = 12;
    localparam int HEIGHT_BITS = 11;

    localparam logic SRC_LINE = 1'b0;
    localparam logic SRC_FILL = 1'b1;

    typedef struct packed {
        logic [WIDTH_BITS-1:0]  x;
        logic [HEIGHT_BITS-1:0] y;
        logic                   src;
    } pix_t;

    function automatic pix_t make_pix(input logic [WIDTH_BITS-1:0] x,
                                      input logic [HEIGHT_BITS-1:0] y,
                                      input logic src);
        pix_t p;
        p.x   = x;
        p.y   = y;
        p.src = src;
        return p;
    endfunction

endpackage

// File: rtl/gpu_sat_counter.sv
// Saturating up-counter; a synchronous clear wins over a coincident increment.
module gpu_sat_counter #(
    parameter int CNT_BITS = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_inc,
    input  logic                i_clr,
    output logic [CNT_BITS-1:0] o_cnt,
    output logic                o_sat
);

    logic [CNT_BITS-1:0] r_cnt;

    // Count accepted events, sticking at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_sat) begin
            r_cnt <= r_cnt + CNT_BITS'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_sat = &r_cnt;
    assign o_cnt = r_cnt;

endmodule

// File: rtl/gpu_pixel_arbiter.sv
// Shares the framebuffer pixel-write path between the line rasterizer and the
// fill unit: line priority with a starvation guard, one-entry output stage.
module gpu_pixel_arbiter
    import gpu_pixel_arbiter_pkg::*;
#(
    parameter int MAX_LINE_BURST = 8,
    parameter int CNT_BITS       = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   line_valid_i,
    output logic                   line_ready_o,
    input  logic [WIDTH_BITS-1:0]  x_line_i,
    input  logic [HEIGHT_BITS-1:0] y_line_i,
    input  logic                   fill_valid_i,
    output logic                   fill_ready_o,
    input  logic [WIDTH_BITS-1:0]  x_fill_i,
    input  logic [HEIGHT_BITS-1:0] y_fill_i,
    output logic                   pix_valid_o,
    input  logic                   pix_ready_i,
    output logic [WIDTH_BITS-1:0]  x_o,
    output logic [HEIGHT_BITS-1:0] y_o,
    output logic                   src_o,
    input  logic                   clear_i,
    output logic [CNT_BITS-1:0]    line_cnt_o,
    output logic [CNT_BITS-1:0]    fill_cnt_o
);

    localparam int BW = $clog2(MAX_LINE_BURST + 1);

    typedef enum logic [0:0] {
        LINE_PRI    = 1'b0,
        FILL_FORCED = 1'b1
    } arb_state_t;

    arb_state_t     r_state;
    logic [BW-1:0]  r_burst;
    logic           r_pix_valid;
    pix_t           r_pix;

    logic           w_slot_free;
    logic           w_grant_line;
    logic           w_grant_fill;
    logic [BW-1:0]  w_burst_inc;
    pix_t           w_win;
    logic           w_line_sat;
    logic           w_fill_sat;

    // Grant selection; the slot is free when empty or being drained this cycle.
    always_comb begin
        w_slot_free  = !r_pix_valid || pix_ready_i;
        w_grant_line = 1'b0;
        w_grant_fill = 1'b0;
        if (rst) begin
            w_grant_line = 1'b0;
            w_grant_fill = 1'b0;
        end else begin
            case (r_state)
                LINE_PRI: begin
                    w_grant_line = w_slot_free && line_valid_i;
                    w_grant_fill = w_slot_free && fill_valid_i && !line_valid_i;
                end
                FILL_FORCED: begin
                    w_grant_fill = w_slot_free && fill_valid_i;
                    w_grant_line = w_slot_free && line_valid_i && !fill_valid_i;
                end
                default: begin
                    w_grant_line = 1'b0;
                    w_grant_fill = 1'b0;
                end
            endcase
        end
    end

    assign w_burst_inc = r_burst + BW'(1);
    assign w_win = w_grant_fill ? make_pix(x_fill_i, y_fill_i, SRC_FILL)
                                : make_pix(x_line_i, y_line_i, SRC_LINE);

    // Starvation guard: count line wins while fill waits, force one fill turn at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LINE_PRI;
            r_burst <= '0;
        end else if (clear_i) begin
            r_state <= LINE_PRI;
            r_burst <= '0;
        end else begin
            case (r_state)
                LINE_PRI: begin
                    if (!fill_valid_i || w_grant_fill) begin
                        r_burst <= '0;
                    end else if (w_grant_line) begin
                        r_burst <= w_burst_inc;
                        if (w_burst_inc >= BW'(MAX_LINE_BURST)) begin
                            r_state <= FILL_FORCED;
                        end else begin
                            r_state <= LINE_PRI;
                        end
                    end else begin
                        r_burst <= r_burst;
                    end
                end
                FILL_FORCED: begin
                    if (!fill_valid_i || w_grant_fill) begin
                        r_state <= LINE_PRI;
                        r_burst <= '0;
                    end else begin
                        r_state <= FILL_FORCED;
                    end
                end
                default: begin
                    r_state <= LINE_PRI;
                    r_burst <= '0;
                end
            endcase
        end
    end

    // One-entry output stage; payload holds after drain so the writer sees no glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix_valid <= 1'b0;
            r_pix       <= '0;
        end else if (w_grant_line || w_grant_fill) begin
            r_pix_valid <= 1'b1;
            r_pix       <= w_win;
        end else if (pix_ready_i) begin
            r_pix_valid <= 1'b0;
        end else begin
            r_pix_valid <= r_pix_valid;
        end
    end

    gpu_sat_counter #(.CNT_BITS(CNT_BITS)) u_line_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_grant_line),
        .i_clr (clear_i),
        .o_cnt (line_cnt_o),
        .o_sat (w_line_sat)
    );

    gpu_sat_counter #(.CNT_BITS(CNT_BITS)) u_fill_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_grant_fill),
        .i_clr (clear_i),
        .o_cnt (fill_cnt_o),
        .o_sat (w_fill_sat)
    );

    assign line_ready_o = w_grant_line;
    assign fill_ready_o = w_grant_fill;
    assign pix_valid_o  = r_pix_valid;
    assign x_o          = r_pix.x;
    assign y_o          = r_pix.y;
    assign src_o        = r_pix.src;

endmodule

// File: tb/tb_gpu_pixel_arbiter.sv
// Directed bench for gpu_pixel_arbiter: hand-computed expectations checked with
// immediate assertions along one linear stimulus sequence.
module tb_gpu_pixel_arbiter;
    import gpu_pixel_arbiter_pkg::*;

    localparam int CNT_BITS = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   line_valid_i = 1'b0;
    logic                   line_ready_o;
    logic [WIDTH_BITS-1:0]  x_line_i = '0;
    logic [HEIGHT_BITS-1:0] y_line_i = '0;
    logic                   fill_valid_i = 1'b0;
    logic                   fill_ready_o;
    logic [WIDTH_BITS-1:0]  x_fill_i = '0;
    logic [HEIGHT_BITS-1:0] y_fill_i = '0;
    logic                   pix_valid_o;
    logic                   pix_ready_i = 1'b0;
    logic [WIDTH_BITS-1:0]  x_o;
    logic [HEIGHT_BITS-1:0] y_o;
    logic                   src_o;
    logic                   clear_i = 1'b0;
    logic [CNT_BITS-1:0]    line_cnt_o;
    logic [CNT_BITS-1:0]    fill_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    gpu_pixel_arbiter #(.MAX_LINE_BURST(8), .CNT_BITS(CNT_BITS)) dut (
        .clk          (clk),
        .rst          (rst),
        .line_valid_i (line_valid_i),
        .line_ready_o (line_ready_o),
        .x_line_i     (x_line_i),
        .y_line_i     (y_line_i),
        .fill_valid_i (fill_valid_i),
        .fill_ready_o (fill_ready_o),
        .x_fill_i     (x_fill_i),
        .y_fill_i     (y_fill_i),
        .pix_valid_o  (pix_valid_o),
        .pix_ready_i  (pix_ready_i),
        .x_o          (x_o),
        .y_o          (y_o),
        .src_o        (src_o),
        .clear_i      (clear_i),
        .line_cnt_o   (line_cnt_o),
        .fill_cnt_o   (fill_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst_pix_valid", 32'(pix_valid_o), 32'd0);
        chk("rst_x", 32'(x_o), 32'd0);
        chk("rst_line_cnt", 32'(line_cnt_o), 32'd0);
        chk("rst_fill_cnt", 32'(fill_cnt_o), 32'd0);
        rst = 1'b0;

        // 1. Line only, writer always ready
        pix_ready_i  = 1'b1;
        line_valid_i = 1'b1;
        y_line_i     = 11'd7;
        for (int i = 0; i < 5; i++) begin
            x_line_i = 12'(i);
            #1;
            chk("t1_line_ready", 32'(line_ready_o), 32'd1);
            tick();
            chk("t1_pix_valid", 32'(pix_valid_o), 32'd1);
            chk("t1_x", 32'(x_o), 32'(i));
            chk("t1_y", 32'(y_o), 32'd7);
            chk("t1_src", 32'(src_o), 32'd0);
        end
        chk("t1_line_cnt", 32'(line_cnt_o), 32'd5);
        line_valid_i = 1'b0;
        tick();
        chk("t1_drained", 32'(pix_valid_o), 32'd0);

        // 2. Both valid: 8 line grants then one forced fill grant, repeating
        line_valid_i = 1'b1;
        fill_valid_i = 1'b1;
        x_line_i     = 12'd100;
        x_fill_i     = 12'd200;
        for (int k = 0; k < 27; k++) begin
            #1;
            chk("t2_line_grant", 32'(line_ready_o), (k % 9 == 8) ? 32'd0 : 32'd1);
            chk("t2_fill_grant", 32'(fill_ready_o), (k % 9 == 8) ? 32'd1 : 32'd0);
            tick();
            chk("t2_src", 32'(src_o), (k % 9 == 8) ? 32'd1 : 32'd0);
        end
        line_valid_i = 1'b0;
        fill_valid_i = 1'b0;
        tick();

        // 3. Back-pressure from the writer
        clear_i = 1'b1;
        tick();
        clear_i      = 1'b0;
        line_valid_i = 1'b1;
        x_line_i     = 12'd33;
        y_line_i     = 11'd3;
        tick();
        pix_ready_i  = 1'b0;
        x_line_i     = 12'd34;
        y_line_i     = 11'd4;
        fill_valid_i = 1'b1;
        x_fill_i     = 12'd44;
        y_fill_i     = 11'd5;
        for (int s = 0; s < 4; s++) begin
            #1;
            chk("t3_line_ready", 32'(line_ready_o), 32'd0);
            chk("t3_fill_ready", 32'(fill_ready_o), 32'd0);
            chk("t3_pix_valid", 32'(pix_valid_o), 32'd1);
            chk("t3_x_hold", 32'(x_o), 32'd33);
            chk("t3_y_hold", 32'(y_o), 32'd3);
            chk("t3_src_hold", 32'(src_o), 32'd0);
            chk("t3_line_cnt", 32'(line_cnt_o), 32'd1);
            chk("t3_fill_cnt", 32'(fill_cnt_o), 32'd0);
            tick();
        end
        pix_ready_i = 1'b1;
        #1;
        chk("t3_release_line", 32'(line_ready_o), 32'd1);
        chk("t3_release_fill", 32'(fill_ready_o), 32'd0);
        tick();
        chk("t3_next_x", 32'(x_o), 32'd34);
        chk("t3_next_y", 32'(y_o), 32'd4);
        chk("t3_next_cnt", 32'(line_cnt_o), 32'd2);
        line_valid_i = 1'b0;
        #1;
        chk("t3_fill_ready2", 32'(fill_ready_o), 32'd1);
        tick();
        chk("t3_fill_x", 32'(x_o), 32'd44);
        chk("t3_fill_src", 32'(src_o), 32'd1);
        chk("t3_fill_cnt2", 32'(fill_cnt_o), 32'd1);
        fill_valid_i = 1'b0;

        // 4. Fill counter saturation at 4 bits
        clear_i = 1'b1;
        tick();
        clear_i      = 1'b0;
        fill_valid_i = 1'b1;
        repeat (20) tick();
        chk("t4_fill_sat", 32'(fill_cnt_o), 32'd15);
        tick();
        chk("t4_fill_sat_hold", 32'(fill_cnt_o), 32'd15);
        chk("t4_line_cnt", 32'(line_cnt_o), 32'd0);
        fill_valid_i = 1'b0;
        tick();

        // 5. Clear coincident with an accepted line pixel, burst at 7
        line_valid_i = 1'b1;
        fill_valid_i = 1'b1;
        x_line_i     = 12'd50;
        x_fill_i     = 12'd60;
        repeat (7) begin
            #1;
            chk("t5_burst_line", 32'(line_ready_o), 32'd1);
            tick();
        end
        chk("t5_line_cnt7", 32'(line_cnt_o), 32'd7);
        x_line_i = 12'd55;
        y_line_i = 11'd9;
        clear_i  = 1'b1;
        #1;
        chk("t5_clr_grant", 32'(line_ready_o), 32'd1);
        tick();
        clear_i = 1'b0;
        chk("t5_line_cnt0", 32'(line_cnt_o), 32'd0);
        chk("t5_x", 32'(x_o), 32'd55);
        chk("t5_y", 32'(y_o), 32'd9);
        chk("t5_pix_valid", 32'(pix_valid_o), 32'd1);
        #1;
        chk("t5_state_line", 32'(line_ready_o), 32'd1);
        chk("t5_state_fill", 32'(fill_ready_o), 32'd0);
        tick();
        chk("t5_line_cnt1", 32'(line_cnt_o), 32'd1);
        line_valid_i = 1'b0;
        fill_valid_i = 1'b0;
        tick();

        // 6. Asynchronous reset with a pixel held
        line_valid_i = 1'b1;
        x_line_i     = 12'd66;
        y_line_i     = 11'd6;
        pix_ready_i  = 1'b0;
        tick();
        chk("t6_held", 32'(x_o), 32'd66);
        chk("t6_cnt_pre", 32'(line_cnt_o), 32'd2);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(pix_valid_o), 32'd0);
        chk("t6_rst_x", 32'(x_o), 32'd0);
        chk("t6_rst_y", 32'(y_o), 32'd0);
        chk("t6_rst_line_cnt", 32'(line_cnt_o), 32'd0);
        chk("t6_rst_ready", 32'(line_ready_o), 32'd0);
        tick();
        rst         = 1'b0;
        pix_ready_i = 1'b1;
        #1;
        chk("t6_post_ready", 32'(line_ready_o), 32'd1);
        tick();
        chk("t6_post_valid", 32'(pix_valid_o), 32'd1);
        chk("t6_post_x", 32'(x_o), 32'd66);
        line_valid_i = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
